// File: rtl/up_regif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : up_regif_pkg
// Purpose  : Shared address map, CTRL/STATUS bit positions and ALU operation
//            encoding for the microprocessor-bus ALU register interface.
// Revision : 1.0 - initial release
// ============================================================================
package up_regif_pkg;

  // Byte address map (byte 0 of each multi-byte field is the LSB)
  localparam logic [3:0] ADDR_OP_A0    = 4'd0;
  localparam logic [3:0] ADDR_OP_A1    = 4'd1;
  localparam logic [3:0] ADDR_OP_A2    = 4'd2;
  localparam logic [3:0] ADDR_OP_A3    = 4'd3;
  localparam logic [3:0] ADDR_OP_B0    = 4'd4;
  localparam logic [3:0] ADDR_OP_B1    = 4'd5;
  localparam logic [3:0] ADDR_OP_B2    = 4'd6;
  localparam logic [3:0] ADDR_OP_B3    = 4'd7;
  localparam logic [3:0] ADDR_RES0     = 4'd8;
  localparam logic [3:0] ADDR_RES1     = 4'd9;
  localparam logic [3:0] ADDR_RES2     = 4'd10;
  localparam logic [3:0] ADDR_RES3     = 4'd11;
  localparam logic [3:0] ADDR_CTRL     = 4'd12;
  localparam logic [3:0] ADDR_STATUS   = 4'd13;
  localparam logic [3:0] ADDR_IRQ_CLR  = 4'd14;
  localparam logic [3:0] ADDR_ID       = 4'd15;

  // CTRL register bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_OP_LSB   = 2;
  localparam int CTRL_OP_MSB   = 3;

  // STATUS register bit positions
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_IRQ_PEND = 2;
  localparam int STAT_WR_ERR   = 3;

  // IRQ_CLR register bit positions
  localparam int IRQCLR_IRQ    = 0;
  localparam int IRQCLR_ERR    = 3;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_SQR = 2'd3
  } alu_op_e;

  // Pick one byte out of a zero-extended 32-bit field view
  function automatic logic [7:0] byte_lane(input logic [31:0] v, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = v[7:0];
      2'd1:    b = v[15:8];
      2'd2:    b = v[23:16];
      default: b = v[31:24];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/up_byte_reg.sv
`default_nettype none
// ============================================================================
// Module   : up_byte_reg
// Purpose  : DATA_W-bit register with per-byte-lane write enables. Lanes whose
//            enable is low hold their value.
// Revision : 1.0 - initial release
// ============================================================================
module up_byte_reg
  import up_regif_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [DATA_W-1:0]     i_d,
  output logic [DATA_W-1:0]     o_q
);

  localparam int NB = DATA_W / 8;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [7:0] r_lane;

    // Each lane loads independently when its enable is set
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lane <= 8'h00;
      end else if (i_be[i]) begin
        r_lane <= i_d[i*8 +: 8];
      end
    end

    assign o_q[i*8 +: 8] = r_lane;
  end

endmodule
`default_nettype wire

// File: rtl/up_alu_regif.sv
`default_nettype none
// ============================================================================
// Module   : up_alu_regif
// Purpose  : 8-bit microprocessor bus responder for the fractal ALU. Decodes
//            16 byte addresses into operand, control, status, result and ID
//            registers, pulses alu_start, captures alu_result on alu_done and
//            raises a level interrupt held until acknowledged.
// Options  : UP_REGIF_SNAPSHOT_EN - reading RESULT byte 0 snapshots the whole
//            result so that bytes 1..3 read back coherently.
// Revision : 1.0 - initial release
// ============================================================================
module up_alu_regif
  import up_regif_pkg::*;
#(
  parameter int           DATA_W   = 32,
  parameter logic [7:0]   ID_VALUE = 8'hA1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pi_blk_sel,
  input  logic                pi_wr_en,
  input  logic                pi_rd_en,
  input  logic [3:0]          pi_addr,
  input  logic [7:0]          pi_wr_data,
  output logic [7:0]          pi_rd_data,
  output logic                interrupt,
  input  logic                interrupt_ack,
  output logic [DATA_W-1:0]   alu_op_a,
  output logic [DATA_W-1:0]   alu_op_b,
  output logic [1:0]          alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [DATA_W-1:0]   alu_result
);

  localparam int NB = DATA_W / 8;

  // Registered state
  logic                r_busy;
  logic                r_done;
  logic                r_irq_pend;
  logic                r_wr_err;
  logic                r_irq_en;
  alu_op_e             r_op;
  logic                r_alu_start;
  logic [DATA_W-1:0]   r_result;
  logic [7:0]          r_rd_data;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;

  // Decode
  logic                w_wr;
  logic                w_rd;
  logic [1:0]          w_lane;
  logic                w_lane_ok;
  logic [NB-1:0]       w_lane_dec;
  logic                w_wr_opa;
  logic                w_wr_opb;
  logic [NB-1:0]       w_be_a;
  logic [NB-1:0]       w_be_b;
  logic [DATA_W-1:0]   w_op_d;
  logic                w_wr_ctrl;
  logic                w_start_ok;
  logic                w_start_err;
  logic                w_op_err;
  logic                w_wr_irqclr;
  logic                w_clr_irq;
  logic                w_clr_err;
  logic                w_done_ok;

  assign w_wr      = pi_blk_sel & pi_wr_en;
  assign w_rd      = pi_blk_sel & pi_rd_en;
  assign w_lane    = pi_addr[1:0];
  assign w_lane_ok = (32'(w_lane) < 32'(NB));

  for (genvar i = 0; i < NB; i++) begin : g_dec
    assign w_lane_dec[i] = (32'(w_lane) == i);
  end

  // Operand writes are frozen while an operation is in flight
  assign w_wr_opa    = w_wr & (pi_addr[3:2] == 2'b00);
  assign w_wr_opb    = w_wr & (pi_addr[3:2] == 2'b01);
  assign w_be_a      = (w_wr_opa & ~r_busy & w_lane_ok) ? w_lane_dec : '0;
  assign w_be_b      = (w_wr_opb & ~r_busy & w_lane_ok) ? w_lane_dec : '0;
  assign w_op_d      = {NB{pi_wr_data}};
  assign w_op_err    = (w_wr_opa | w_wr_opb) & r_busy;

  assign w_wr_ctrl   = w_wr & (pi_addr == ADDR_CTRL);
  assign w_start_ok  = w_wr_ctrl & pi_wr_data[CTRL_START] & ~r_busy;
  assign w_start_err = w_wr_ctrl & pi_wr_data[CTRL_START] & r_busy;

  assign w_wr_irqclr = w_wr & (pi_addr == ADDR_IRQ_CLR);
  assign w_clr_irq   = w_wr_irqclr & pi_wr_data[IRQCLR_IRQ];
  assign w_clr_err   = w_wr_irqclr & pi_wr_data[IRQCLR_ERR];

  // A completion pulse only counts when an operation is outstanding
  assign w_done_ok   = alu_done & r_busy;

  up_byte_reg #(.DATA_W(DATA_W)) u_op_a (
    .clk  (clk),
    .rst  (rst),
    .i_be (w_be_a),
    .i_d  (w_op_d),
    .o_q  (r_op_a)
  );

  up_byte_reg #(.DATA_W(DATA_W)) u_op_b (
    .clk  (clk),
    .rst  (rst),
    .i_be (w_be_b),
    .i_d  (w_op_d),
    .o_q  (r_op_b)
  );

  // Control, status and interrupt state; a set always beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_irq_pend  <= 1'b0;
      r_wr_err    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_op        <= ALU_ADD;
      r_alu_start <= 1'b0;
    end else begin
      r_alu_start <= w_start_ok;

      if (w_wr_ctrl) begin
        r_irq_en <= pi_wr_data[CTRL_IRQ_EN];
        r_op     <= alu_op_e'(pi_wr_data[CTRL_OP_MSB:CTRL_OP_LSB]);
      end

      if (w_start_ok) begin
        r_busy <= 1'b1;
      end else if (w_done_ok) begin
        r_busy <= 1'b0;
      end

      if (w_done_ok) begin
        r_done <= 1'b1;
      end else if (w_start_ok | w_clr_irq) begin
        r_done <= 1'b0;
      end

      if (w_done_ok & r_irq_en) begin
        r_irq_pend <= 1'b1;
      end else if (w_clr_irq | interrupt_ack) begin
        r_irq_pend <= 1'b0;
      end

      if (w_start_err | w_op_err) begin
        r_wr_err <= 1'b1;
      end else if (w_clr_err) begin
        r_wr_err <= 1'b0;
      end
    end
  end

  // Result capture on a qualified completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_done_ok) begin
      r_result <= alu_result;
    end
  end

  // Result view presented to the read mux
  logic [31:0] w_res_view32;

`ifdef UP_REGIF_SNAPSHOT_EN
  logic [DATA_W-1:0] r_shadow;
  logic [NB-1:0]     w_be_shadow;

  assign w_be_shadow = (w_rd && (pi_addr == ADDR_RES0)) ? '1 : '0;

  up_byte_reg #(.DATA_W(DATA_W)) u_shadow (
    .clk  (clk),
    .rst  (rst),
    .i_be (w_be_shadow),
    .i_d  (r_result),
    .o_q  (r_shadow)
  );

  // Byte 0 comes live (it is being snapshotted this edge), the rest from the shadow
  assign w_res_view32 = (pi_addr == ADDR_RES0) ? 32'(r_result) : 32'(r_shadow);
`else
  assign w_res_view32 = 32'(r_result);
`endif

  // Read mux; zero-extended views make unused upper lanes read 0x00
  logic [31:0] w_op_a32;
  logic [31:0] w_op_b32;
  logic [7:0]  w_ctrl;
  logic [7:0]  w_status;
  logic [7:0]  w_rd_byte;

  assign w_op_a32 = 32'(r_op_a);
  assign w_op_b32 = 32'(r_op_b);

  // Assemble CTRL/STATUS readback and select the addressed byte
  always_comb begin
    w_ctrl                          = 8'h00;
    w_ctrl[CTRL_IRQ_EN]             = r_irq_en;
    w_ctrl[CTRL_OP_MSB:CTRL_OP_LSB] = r_op;
    w_status                        = 8'h00;
    w_status[STAT_BUSY]             = r_busy;
    w_status[STAT_DONE]             = r_done;
    w_status[STAT_IRQ_PEND]         = r_irq_pend;
    w_status[STAT_WR_ERR]           = r_wr_err;
    w_rd_byte                       = 8'h00;
    case (pi_addr)
      ADDR_OP_A0, ADDR_OP_A1, ADDR_OP_A2, ADDR_OP_A3: w_rd_byte = byte_lane(w_op_a32, w_lane);
      ADDR_OP_B0, ADDR_OP_B1, ADDR_OP_B2, ADDR_OP_B3: w_rd_byte = byte_lane(w_op_b32, w_lane);
      ADDR_RES0, ADDR_RES1, ADDR_RES2, ADDR_RES3:     w_rd_byte = byte_lane(w_res_view32, w_lane);
      ADDR_CTRL:    w_rd_byte = w_ctrl;
      ADDR_STATUS:  w_rd_byte = w_status;
      ADDR_ID:      w_rd_byte = ID_VALUE;
      default:      w_rd_byte = 8'h00;
    endcase
  end

  // Registered read data, zero when no read was sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= w_rd ? w_rd_byte : 8'h00;
    end
  end

  assign pi_rd_data = r_rd_data;
  assign interrupt  = r_irq_pend;
  assign alu_op_a   = r_op_a;
  assign alu_op_b   = r_op_b;
  assign alu_op     = r_op;
  assign alu_start  = r_alu_start;

endmodule
`default_nettype wire

// File: tb/tb_up_alu_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_alu_regif
// Purpose  : Self-checking bench for up_alu_regif: directed register-map steps
//            followed by randomized bus/ALU traffic, checked cycle by cycle
//            against a register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_alu_regif;

  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pi_blk_sel = 1'b0;
  logic              pi_wr_en = 1'b0;
  logic              pi_rd_en = 1'b0;
  logic [3:0]        pi_addr = 4'h0;
  logic [7:0]        pi_wr_data = 8'h00;
  logic [7:0]        pi_rd_data;
  logic              interrupt;
  logic              interrupt_ack = 1'b0;
  logic [DATA_W-1:0] alu_op_a;
  logic [DATA_W-1:0] alu_op_b;
  logic [1:0]        alu_op;
  logic              alu_start;
  logic              alu_done = 1'b0;
  logic [DATA_W-1:0] alu_result = '0;

  int checks = 0;
  int errors = 0;

  up_alu_regif #(.DATA_W(DATA_W), .ID_VALUE(8'hA1)) dut (
    .clk           (clk),
    .rst           (rst),
    .pi_blk_sel    (pi_blk_sel),
    .pi_wr_en      (pi_wr_en),
    .pi_rd_en      (pi_rd_en),
    .pi_addr       (pi_addr),
    .pi_wr_data    (pi_wr_data),
    .pi_rd_data    (pi_rd_data),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .alu_op_a      (alu_op_a),
    .alu_op_b      (alu_op_b),
    .alu_op        (alu_op),
    .alu_start     (alu_start),
    .alu_done      (alu_done),
    .alu_result    (alu_result)
  );

  always #5 clk = ~clk;

  // Reference model: the programmer-visible registers as plain values
  logic [DATA_W-1:0] m_a, m_b, m_res, m_shadow;
  logic [1:0]        m_op;
  bit                m_irq_en, m_busy, m_done, m_irq, m_err, m_start;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_res = '0; m_shadow = '0; m_op = 2'd0;
    m_irq_en = 0; m_busy = 0; m_done = 0; m_irq = 0; m_err = 0; m_start = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] a);
    logic [DATA_W-1:0] t;
    int ln;
    ln = int'(a[1:0]);
    if (a < 4'd12 && ln >= NB) return 8'h00;
    if (a < 4'd4)       t = m_a >> (8 * ln);
    else if (a < 4'd8)  t = m_b >> (8 * ln);
    else if (a < 4'd12) begin
`ifdef UP_REGIF_SNAPSHOT_EN
      t = (a == 4'd8) ? m_res : (m_shadow >> (8 * ln));
`else
      t = m_res >> (8 * ln);
`endif
    end
    else if (a == 4'd12) return {4'h0, m_op, m_irq_en, 1'b0};
    else if (a == 4'd13) return {4'h0, m_err, m_irq, m_done, m_busy};
    else if (a == 4'd15) return 8'hA1;
    else return 8'h00;
    return t[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, predict from the pre-edge model state, then compare
  task automatic step(input bit sel, input bit wr, input bit rd, input logic [3:0] a,
                      input logic [7:0] d, input bit dn, input logic [DATA_W-1:0] res,
                      input bit ack);
    logic [7:0]        exp_rd;
    logic [DATA_W-1:0] lane_mask;
    bit                p_busy, p_irq_en;
    int                ln;
    pi_blk_sel = sel; pi_wr_en = wr; pi_rd_en = rd; pi_addr = a; pi_wr_data = d;
    alu_done = dn; alu_result = res; interrupt_ack = ack;

    exp_rd   = (sel && rd) ? m_read(a) : 8'h00;
`ifdef UP_REGIF_SNAPSHOT_EN
    if (sel && rd && a == 4'd8) m_shadow = m_res;
`endif
    p_busy   = m_busy;
    p_irq_en = m_irq_en;
    m_start  = 0;
    ln       = int'(a[1:0]);

    if (sel && wr) begin
      if (a < 4'd8) begin
        if (p_busy) m_err = 1;
        else if (ln < NB) begin
          lane_mask = DATA_W'(8'hFF) << (8 * ln);
          if (a < 4'd4) m_a = (m_a & ~lane_mask) | (DATA_W'(d) << (8 * ln));
          else          m_b = (m_b & ~lane_mask) | (DATA_W'(d) << (8 * ln));
        end
      end else if (a == 4'd12) begin
        m_irq_en = d[1];
        m_op     = d[3:2];
        if (d[0]) begin
          if (p_busy) m_err = 1;
          else begin m_start = 1; m_busy = 1; m_done = 0; end
        end
      end else if (a == 4'd14) begin
        if (d[0]) begin m_irq = 0; m_done = 0; end
        if (d[3]) m_err = 0;
      end
    end
    if (ack) m_irq = 0;
    if (dn && p_busy) begin
      m_res = res; m_busy = 0; m_done = 1;
      if (p_irq_en) m_irq = 1;
    end

    @(posedge clk); #1;
    chk("rd_data",   32'(pi_rd_data), 32'(exp_rd));
    chk("interrupt", 32'(interrupt),  32'(m_irq));
    chk("alu_start", 32'(alu_start),  32'(m_start));
    chk("alu_op_a",  32'(alu_op_a),   32'(m_a));
    chk("alu_op_b",  32'(alu_op_b),   32'(m_b));
    chk("alu_op",    32'(alu_op),     32'(m_op));
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    step(1, 1, 0, a, d, 0, '0, 0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1, 0, 1, a, 8'h00, 0, '0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 4'h0, 8'h00, 0, '0, 0);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once
  task automatic do_reset();
    pi_blk_sel = 0; pi_wr_en = 0; pi_rd_en = 0; alu_done = 0; interrupt_ack = 0;
    rst = 1;
    #2;
    model_reset();
    chk("rst_interrupt", 32'(interrupt),  32'(0));
    chk("rst_alu_start", 32'(alu_start),  32'(0));
    chk("rst_rd_data",   32'(pi_rd_data), 32'(0));
    chk("rst_op_a",      32'(alu_op_a),   32'(0));
    #2;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          s_sel, s_wr, s_rd, s_dn, s_ack;
    logic [3:0]  s_a;
    logic [7:0]  s_d;
    logic [31:0] s_res;

    model_reset();
    #3;
    do_reset();

    // ID and idle status
    rd(4'd15);
    chk("id_value", 32'(pi_rd_data), 32'hA1);
    rd(4'd13);
    chk("status_idle", 32'(pi_rd_data), 32'h00);

    // Operand A load, simultaneous read/write returns the old byte
    wr(4'd0, 8'h78);
    step(1, 1, 1, 4'd0, 8'h99, 0, '0, 0);
    chk("rd_pre_write", 32'(pi_rd_data), 32'h78);
    wr(4'd0, 8'h78);
    wr(4'd1, 8'h56);
    wr(4'd2, 8'h34);
    wr(4'd3, 8'h12);
    wr(4'd12, 8'h07);
    chk("op_a_value", 32'(alu_op_a), 32'h12345678);
    chk("start_high", 32'(alu_start), 32'd1);
    rd(4'd13);
    chk("start_one_cycle", 32'(alu_start), 32'd0);
    chk("status_busy", 32'(pi_rd_data), 32'h01);

    // Completion with interrupt enabled
    step(0, 0, 0, 4'd0, 8'h00, 1, 32'hDEADBEEF, 0);
    chk("irq_after_done", 32'(interrupt), 32'd1);
    rd(4'd13);
    chk("status_done_irq", 32'(pi_rd_data), 32'h06);
    rd(4'd8);  chk("res_b0", 32'(pi_rd_data), 32'hEF);
    rd(4'd9);  chk("res_b1", 32'(pi_rd_data), 32'hBE);
    rd(4'd10); chk("res_b2", 32'(pi_rd_data), 32'hAD);
    rd(4'd11); chk("res_b3", 32'(pi_rd_data), 32'hDE);
    step(0, 0, 0, 4'd0, 8'h00, 0, '0, 1);
    chk("irq_acked", 32'(interrupt), 32'd0);

    // Busy protection: operand write and restart rejected, wr_err raised
    wr(4'd12, 8'h07);
    wr(4'd4, 8'hFF);
    chk("op_b_frozen", 32'(alu_op_b), 32'h0);
    wr(4'd12, 8'h01);
    chk("no_restart", 32'(alu_start), 32'd0);
    rd(4'd13);
    chk("wr_err_set", 32'(pi_rd_data[3]), 32'd1);
    wr(4'd14, 8'h08);
    rd(4'd13);
    chk("wr_err_clr", 32'(pi_rd_data[3]), 32'd0);

    // Ack coincident with a qualifying completion: set wins
    wr(4'd12, 8'h06);
    step(0, 0, 0, 4'd0, 8'h00, 1, 32'h0000_1234, 1);
    chk("irq_set_wins", 32'(interrupt), 32'd1);
    rd(4'd9);
    wr(4'd14, 8'h01);
    chk("irq_clr_write", 32'(interrupt), 32'd0);

    // Reset while busy, then a spurious completion
    wr(4'd12, 8'h03);
    do_reset();
    step(0, 0, 0, 4'd0, 8'h00, 1, 32'hCAFEF00D, 0);
    chk("spurious_irq", 32'(interrupt), 32'd0);
    rd(4'd13);
    chk("spurious_status", 32'(pi_rd_data), 32'h00);
    rd(4'd8);
    chk("spurious_result", 32'(pi_rd_data), 32'h00);

    // Randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      s_sel = ($urandom_range(0, 7) != 0);
      s_wr  = $urandom_range(0, 1) != 0;
      s_rd  = $urandom_range(0, 1) != 0;
      s_a   = ($urandom_range(0, 3) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
      s_d   = 8'($urandom);
      s_dn  = ($urandom_range(0, 4) == 0);
      s_res = $urandom;
      s_ack = ($urandom_range(0, 7) == 0);
      step(s_sel, s_wr, s_rd, s_a, s_d, s_dn, s_res, s_ack);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
